// File: rtl/dmem_req_stage.sv
// Data-memory request stage: captures a load/store, issues it on AXI-lite AW/W/AR and hands it to MEM.
// Optional build macro MISALIGN_CHECK_EN turns misaligned LH/LHU/SH/LW/SW into exceptions instead of issuing them.
module dmem_req_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        flush_in,
  output logic        valid_out,
  input  logic        ready_in,
  input  logic [31:0] PC_in,
  input  logic        load_in,
  input  logic        store_in,
  input  logic [2:0]  mem_op_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        exc_pend_in,
  input  logic [31:0] exc_cause_in,
  output logic [31:0] PC_out,
  output logic        load_out,
  output logic        store_out,
  output logic [2:0]  mem_op_out,
  output logic        exc_pend_out,
  output logic [31:0] exc_cause_out,
  output logic [31:0] dmem_axi_awaddr,
  output logic        dmem_axi_awvalid,
  input  logic        dmem_axi_awready,
  output logic [31:0] dmem_axi_wdata,
  output logic [3:0]  dmem_axi_wstrb,
  output logic        dmem_axi_wvalid,
  input  logic        dmem_axi_wready,
  output logic [31:0] dmem_axi_araddr,
  output logic        dmem_axi_arvalid,
  input  logic        dmem_axi_arready,
  input  logic        dmem_axi_bvalid,
  input  logic        dmem_axi_rvalid,
  output logic        bready_drain,
  output logic        rready_drain
);

  // state | meaning
  // IDLE  | empty, accepting a request
  // ISSUE | AW/W/AR channels outstanding
  // HOLD  | request presented to MEM (valid_out)
  // DRAIN | flushed access: finish channels, swallow the response
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]  state, state_nxt;
  logic        aw_pend, w_pend, ar_pend;
  logic        acc_q;
  logic [31:0] addr_q;
  logic        capture;
  logic        misalign;
  logic        exc_new;
  logic        acc_new;
  logic [31:0] cause_new;
  logic [3:0]  strb_new;
  logic [31:0] wdata_new;
  logic        pend_left;
  logic        any_pend;
  logic        drain_done;

  assign ready_out = (state == ST_IDLE) || ((state == ST_HOLD) && ready_in);
  assign capture   = valid_in && ready_out && !flush_in;
  assign valid_out = (state == ST_HOLD);

  assign dmem_axi_awvalid = aw_pend;
  assign dmem_axi_wvalid  = w_pend;
  assign dmem_axi_arvalid = ar_pend;
  assign dmem_axi_awaddr  = addr_q;
  assign dmem_axi_araddr  = addr_q;

`ifdef MISALIGN_CHECK_EN
  assign misalign = (load_in || store_in) &&
                    (((mem_op_in[1:0] == 2'b01) && addr_in[0]) ||
                     ((mem_op_in[1:0] == 2'b10) && (addr_in[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign exc_new = exc_pend_in || misalign;
  assign acc_new = (load_in || store_in) && !exc_new;

  always_comb begin
    cause_new = 32'd0;
    if (exc_pend_in)   cause_new = exc_cause_in;
    else if (misalign) cause_new = store_in ? 32'd6 : 32'd4;
  end

  always_comb begin
    strb_new = 4'b0000;
    if (store_in && acc_new) begin
      case (mem_op_in[1:0])
        2'b00:   strb_new = 4'b0001 << addr_in[1:0];
        2'b01:   strb_new = 4'b0011 << addr_in[1:0];
        default: strb_new = 4'b1111;
      endcase
    end
  end

  assign wdata_new = wdata_in << {addr_in[1:0], 3'b000};

  // channels still waiting after this cycle's handshakes
  assign pend_left  = (aw_pend && !dmem_axi_awready) || (w_pend && !dmem_axi_wready) ||
                      (ar_pend && !dmem_axi_arready);
  assign any_pend   = aw_pend || w_pend || ar_pend;
  assign drain_done = (!store_out || dmem_axi_bvalid) && (!load_out || dmem_axi_rvalid);

  assign bready_drain = (state == ST_DRAIN) && !any_pend && store_out;
  assign rready_drain = (state == ST_DRAIN) && !any_pend && load_out;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (capture) state_nxt = acc_new ? ST_ISSUE : ST_HOLD;
      end
      ST_ISSUE: begin
        if (flush_in)        state_nxt = ST_DRAIN;
        else if (!pend_left) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (flush_in)     state_nxt = acc_q ? ST_DRAIN : ST_IDLE;
        else if (capture) state_nxt = acc_new ? ST_ISSUE : ST_HOLD;
        else if (ready_in) state_nxt = ST_IDLE;
      end
      default: begin
        if (!any_pend && drain_done) state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      aw_pend        <= 1'b0;
      w_pend         <= 1'b0;
      ar_pend        <= 1'b0;
      acc_q          <= 1'b0;
      addr_q         <= 32'd0;
      dmem_axi_wdata <= 32'd0;
      dmem_axi_wstrb <= 4'd0;
      PC_out         <= 32'd0;
      load_out       <= 1'b0;
      store_out      <= 1'b0;
      mem_op_out     <= 3'd0;
      exc_pend_out   <= 1'b0;
      exc_cause_out  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        aw_pend        <= acc_new && store_in;
        w_pend         <= acc_new && store_in;
        ar_pend        <= acc_new && load_in;
        acc_q          <= acc_new;
        addr_q         <= addr_in;
        dmem_axi_wdata <= wdata_new;
        dmem_axi_wstrb <= strb_new;
        PC_out         <= PC_in;
        load_out       <= load_in;
        store_out      <= store_in;
        mem_op_out     <= mem_op_in;
        exc_pend_out   <= exc_new;
        exc_cause_out  <= cause_new;
      end else if ((state == ST_ISSUE) || (state == ST_DRAIN)) begin
        if (dmem_axi_awready) aw_pend <= 1'b0;
        if (dmem_axi_wready)  w_pend  <= 1'b0;
        if (dmem_axi_arready) ar_pend <= 1'b0;
      end
    end
  end

endmodule
